uart_rx_frame: RTL

//  UART receiver: deserialises the LSB-first frame produced by the team's UART transmitter
//  (idle 1, start 0, D_WIDTH data bits, stop 1) back into parallel words.

---
 rtl/uart_rx_frame_if.sv | 28 ++
 rtl/uart_rx_frame.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_frame_if
//  Brief    : Serial line and received-word handshake bundle for uart_rx_frame.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_frame_if #(
    parameter int D_WIDTH = 6
);
    logic               rx;
    logic               rx_ready;
    logic [D_WIDTH-1:0] rx_data;
    logic               rx_valid;
    logic               rx_busy;
    logic               frame_err;
    logic               rx_overrun;

    // master = the receiver producing words; slave = line driver plus consumer
    modport master (
        input  rx, rx_ready,
        output rx_data, rx_valid, rx_busy, frame_err, rx_overrun
    );
    modport slave (
        output rx, rx_ready,
        input  rx_data, rx_valid, rx_busy, frame_err, rx_overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_frame
//  Brief    : LSB-first UART receiver (start 0, D_WIDTH data, stop 1) with a
//             valid/ready word output and framing/overrun pulses.
//             Optional input synchroniser: define UART_RX_SYNC_EN.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_frame #(
    parameter int D_WIDTH      = 6,
    parameter int CLKS_PER_BIT = 1
) (
    input wire              clk,
    input wire              rst,
    uart_rx_frame_if.master bus
);
    localparam int CNT_W   = $clog2(CLKS_PER_BIT*(D_WIDTH+2)) + 1;
    localparam int c_half  = (CLKS_PER_BIT-1)/2;
    localparam int c_bit_w = $clog2(D_WIDTH) + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic w_rx;

`ifdef UART_RX_SYNC_EN
    logic [1:0] r_sync;
    always_ff @(posedge clk) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], bus.rx};
    end
    assign w_rx = r_sync[1];
`else
    assign w_rx = bus.rx;
`endif

    state_t             r_state,  w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [CNT_W-1:0]   r_target, w_target_nxt;
    logic [c_bit_w-1:0] r_bit,    w_bit_nxt;
    logic [D_WIDTH-1:0] r_shift,  w_shift_nxt;
    logic [D_WIDTH-1:0] r_data,   w_data_nxt;
    logic               r_valid,  w_valid_nxt;
    logic               r_busy,   w_busy_nxt;
    logic               r_ferr,   w_ferr_nxt;
    logic               r_ovr,    w_ovr_nxt;
    logic               w_hit;

    // r_cnt holds (edges since t) - 1, so the edge being taken is r_cnt + 1
    assign w_hit = ((r_cnt + CNT_W'(1)) == r_target);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_target <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_target <= w_target_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
            r_busy   <= w_busy_nxt;
            r_ferr   <= w_ferr_nxt;
            r_ovr    <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_target_nxt = r_target;
        w_bit_nxt    = r_bit;
        w_shift_nxt  = r_shift;
        w_data_nxt   = r_data;
        w_valid_nxt  = r_valid & ~bus.rx_ready;
        w_busy_nxt   = r_busy;
        w_ferr_nxt   = 1'b0;
        w_ovr_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = r_cnt;
                if (!w_rx) begin
                    w_cnt_nxt  = '0;
                    w_busy_nxt = 1'b1;
                    w_bit_nxt  = '0;
                    // With a zero half-bit offset the start check is this very edge
                    if (c_half == 0) begin
                        w_state_nxt  = ST_DATA;
                        w_target_nxt = CNT_W'(CLKS_PER_BIT + c_half);
                    end else begin
                        w_state_nxt  = ST_START;
                        w_target_nxt = CNT_W'(c_half);
                    end
                end
            end
            ST_START: begin
                if (w_hit) begin
                    if (w_rx) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_state_nxt  = ST_DATA;
                        w_target_nxt = r_target + CNT_W'(CLKS_PER_BIT);
                    end
                end
            end
            ST_DATA: begin
                if (w_hit) begin
                    w_shift_nxt  = {w_rx, r_shift[D_WIDTH-1:1]};
                    w_bit_nxt    = r_bit + c_bit_w'(1);
                    w_target_nxt = r_target + CNT_W'(CLKS_PER_BIT);
                    if (r_bit == c_bit_w'(D_WIDTH-1))
                        w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_hit) begin
                    w_busy_nxt = 1'b0;
                    if (w_rx) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_ovr_nxt   = r_valid & ~bus.rx_ready;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                w_cnt_nxt = r_cnt;
                if (w_rx)
                    w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.rx_data    = r_data;
    assign bus.rx_valid   = r_valid;
    assign bus.rx_busy    = r_busy;
    assign bus.frame_err  = r_ferr;
    assign bus.rx_overrun = r_ovr;

endmodule
`default_nettype wire
